// File: rtl/pipe_pkg.sv
// Shared pipeline bus layouts for the execute -> memory -> write-back path.
// Packed structs fix the field offsets; the MS->WS payload is identical on both sides.
package pipe_pkg;
  localparam int ES2MS_W   = 212;
  localparam int MS2WS_W   = 206;
  localparam int MS2DS_W   = 39;
  localparam int LOAD_OP_W = 5;

  // load_op = {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  // csr_data[33:32] carry the read/write enables of csrrd/csrwr/csrxchg
  localparam int CSR_RE_BIT = 33;
  localparam int CSR_WE_BIT = 32;

  typedef struct packed {
    logic        inst_rdcntid;   // [205]
    logic [31:0] addr_error;     // [204:173]
    logic        ds_has_int;     // [172]
    logic [3:0]  exception_op;   // [171:168]
    logic [31:0] rj_value;       // [167:136]
    logic [31:0] rkd_value;      // [135:104]
    logic [33:0] csr_data;       // [103:70]
    logic        gr_we;          // [69]
    logic [4:0]  dest;           // [68:64]
    logic [31:0] final_result;   // [63:32]
    logic [31:0] pc;             // [31:0]
  } ms_payload_t;

  typedef struct packed {
    logic                 res_from_mem;  // [211]
    logic [LOAD_OP_W-1:0] load_op;       // [210:206]
    ms_payload_t          payload;       // [205:0]
  } es_to_ms_t;
endpackage

// File: rtl/mem_load_ext.sv
// Load data aligner: picks the addressed byte/half from the SRAM word and extends it.
module mem_load_ext
  import pipe_pkg::*;
(
  input  logic [1:0]           addr_i,
  input  logic [LOAD_OP_W-1:0] load_op_i,
  input  logic [31:0]          rdata_i,
  output logic [31:0]          result_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    result_o = '0;
    if      (load_op_i[LD_B])  result_o = {{24{byte_sel[7]}}, byte_sel};
    else if (load_op_i[LD_BU]) result_o = {24'd0, byte_sel};
    else if (load_op_i[LD_H])  result_o = {{16{half_sel[15]}}, half_sel};
    else if (load_op_i[LD_HU]) result_o = {16'd0, half_sel};
    else if (load_op_i[LD_W])  result_o = rdata_i;
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: waits for load data, aligns it, and drops SRAM responses
// that belong to instructions killed by a write-back flush.
module mem_stage
  import pipe_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               es_to_ms_valid,
  input  logic [ES2MS_W-1:0] es_to_ms_bus,
  input  logic               es_req_outstanding,
  output logic               ms_allowin,
  input  logic               ws_allowin,
  output logic               ms_to_ws_valid,
  output logic [MS2WS_W-1:0] ms_to_ws_bus,
  input  logic               data_sram_data_ok,
  input  logic [31:0]        data_sram_rdata,
  input  logic               flush,
  output logic [MS2DS_W-1:0] ms_to_ds_bus,
  output logic               ms_load_block,
  output logic               ms_csr_block,
  output logic               ms_ex
);
  logic        ms_valid_q, ms_valid_d;
  es_to_ms_t   bus_q;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [1:0]  cancel_cnt_q, cancel_cnt_d;

  logic        accept, drop_now, waiting, ms_ready_go, leave;
  logic [2:0]  cnt_sum;
  logic [31:0] ext_result, fwd_data;
  ms_payload_t pl_out;

  mem_load_ext u_ext (
    .addr_i    (bus_q.payload.final_result[1:0]),
    .load_op_i (bus_q.load_op),
    .rdata_i   (buf_valid_q ? buf_data_q : data_sram_rdata),
    .result_o  (ext_result)
  );

  always_comb begin
    accept         = data_sram_data_ok && (cancel_cnt_q == 2'd0);
    drop_now       = data_sram_data_ok && (cancel_cnt_q != 2'd0);
    waiting        = ms_valid_q && bus_q.res_from_mem && !buf_valid_q;
    ms_ready_go    = !bus_q.res_from_mem || buf_valid_q || accept;
    ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
    leave          = ms_to_ws_valid && ws_allowin;
  end

  always_comb begin
    ms_valid_d   = ms_valid_q;
    buf_valid_d  = buf_valid_q;
    buf_data_d   = buf_data_q;
    cancel_cnt_d = cancel_cnt_q - {1'b0, drop_now};
    // in-flight responses of the waiting MS load and of the ES load both become stale
    cnt_sum      = {1'b0, cancel_cnt_q} + {2'b0, waiting && !accept}
                 + {2'b0, es_req_outstanding} - {2'b0, drop_now};

    if (flush)           ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;

    if (flush || leave) begin
      buf_valid_d = 1'b0;
    end else if (waiting && accept) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end

    if (flush) cancel_cnt_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_valid_q   <= 1'b0;
      bus_q        <= '0;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= '0;
      cancel_cnt_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
      cancel_cnt_q <= cancel_cnt_d;
      if (es_to_ms_valid && ms_allowin) bus_q <= es_to_ms_t'(es_to_ms_bus);
    end
  end

  always_comb begin
    fwd_data            = bus_q.res_from_mem ? ext_result : bus_q.payload.final_result;
    pl_out              = bus_q.payload;
    pl_out.final_result = fwd_data;
    ms_to_ws_bus        = pl_out;
    ms_to_ds_bus        = {ms_valid_q, bus_q.payload.gr_we && ms_valid_q,
                           bus_q.payload.dest, fwd_data};
    ms_load_block       = waiting && !accept;
    ms_csr_block        = ms_valid_q && (bus_q.payload.csr_data[CSR_RE_BIT] ||
                          bus_q.payload.csr_data[CSR_WE_BIT] || bus_q.payload.inst_rdcntid);
    ms_ex               = ms_valid_q && (|bus_q.payload.exception_op || bus_q.payload.ds_has_int);
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load extension, buffering,
// flush cancellation and async reset.
module tb_mem_stage;
  import pipe_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               es_to_ms_valid;
  logic [ES2MS_W-1:0] es_to_ms_bus;
  logic               es_req_outstanding;
  logic               ms_allowin;
  logic               ws_allowin;
  logic               ms_to_ws_valid;
  logic [MS2WS_W-1:0] ms_to_ws_bus;
  logic               data_sram_data_ok;
  logic [31:0]        data_sram_rdata;
  logic               flush;
  logic [MS2DS_W-1:0] ms_to_ds_bus;
  logic               ms_load_block, ms_csr_block, ms_ex;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .es_req_outstanding(es_req_outstanding), .ms_allowin(ms_allowin),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .ms_to_ds_bus(ms_to_ds_bus), .ms_load_block(ms_load_block),
    .ms_csr_block(ms_csr_block), .ms_ex(ms_ex)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [ES2MS_W-1:0] mk(input logic rfm, input logic [4:0] op,
      input logic [4:0] dest, input logic [31:0] res, input logic [3:0] exop, input logic csr_re);
    es_to_ms_t b;
    b = '0;
    b.res_from_mem         = rfm;
    b.load_op              = op;
    b.payload.gr_we        = 1'b1;
    b.payload.dest         = dest;
    b.payload.final_result = res;
    b.payload.pc           = 32'h1c00_0100;
    b.payload.exception_op = exop;
    b.payload.csr_data     = {csr_re, 33'd0};
    return b;
  endfunction

  function automatic logic [31:0] fres();
    return ms_to_ws_bus[63:32];
  endfunction

  // drive at negedge, then settle before checking
  task automatic nedge();
    @(negedge clk);
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    flush             = 1'b0;
    es_req_outstanding = 1'b0;
  endtask

  task automatic enter(input logic [ES2MS_W-1:0] b);
    nedge();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    #1;
  endtask

  // load enters, waits one cycle, then data_ok with ws_allowin high
  task automatic run_load(input string tag, input int op, input logic [31:0] addr,
      input logic [31:0] rdata, input logic [31:0] exp);
    enter(mk(1'b1, 5'(1 << op), 5'd9, addr, 4'd0, 1'b0));
    nedge(); #1;
    chk({tag, "_blk"}, ms_load_block, 1);
    nedge(); data_sram_data_ok = 1'b1; data_sram_rdata = rdata; #1;
    chk({tag, "_vld"}, ms_to_ws_valid, 1);
    chk({tag, "_res"}, fres(), exp);
  endtask

  initial begin
    reset = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; es_req_outstanding = 1'b0;
    ws_allowin = 1'b1; data_sram_data_ok = 1'b0; data_sram_rdata = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_to_ws", ms_to_ws_valid, 0);
    chk("rst_blocks", {ms_load_block, ms_csr_block, ms_ex}, 3'b000);
    reset = 1'b1;

    // ALU op: valid one cycle after entry, forwarded
    enter(mk(1'b0, 5'd0, 5'd5, 32'h1234_5678, 4'd0, 1'b0));
    nedge(); #1;
    chk("alu_vld", ms_to_ws_valid, 1);
    chk("alu_res", fres(), 32'h1234_5678);
    chk("alu_ds", ms_to_ds_bus, {1'b1, 1'b1, 5'd5, 32'h1234_5678});
    nedge(); #1;
    chk("alu_gone", ms_to_ws_valid, 0);

    // ld_b with two wait cycles
    enter(mk(1'b1, 5'b10000, 5'd7, 32'h0000_1003, 4'd0, 1'b0));
    nedge(); #1;
    chk("ldb_blk1", {ms_load_block, ms_allowin, ms_to_ws_valid}, 3'b100);
    nedge(); #1;
    chk("ldb_blk2", {ms_load_block, ms_allowin, ms_to_ws_valid}, 3'b100);
    nedge(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000; #1;
    chk("ldb_vld", {ms_to_ws_valid, ms_load_block}, 2'b10);
    chk("ldb_res", fres(), 32'hFFFF_FF80);
    chk("ldb_fwd", ms_to_ds_bus[31:0], 32'hFFFF_FF80);

    run_load("ldhu", LD_HU, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001);
    run_load("ldh",  LD_H,  32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001);
    run_load("ldbu", LD_BU, 32'h0000_2000, 32'h1234_80AB, 32'h0000_00AB);
    run_load("ldb1", LD_B,  32'h0000_2001, 32'h1234_80AB, 32'hFFFF_FF80);
    run_load("ldw",  LD_W,  32'h0000_2004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // response while write-back stalls -> buffered
    enter(mk(1'b1, 5'b00001, 5'd3, 32'h0000_3000, 4'd0, 1'b0));
    nedge(); ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_BABE; #1;
    chk("buf_allowin0", ms_allowin, 0);
    nedge(); ws_allowin = 1'b0; data_sram_rdata = 32'h0; #1;
    chk("buf_hold_vld", {ms_to_ws_valid, ms_load_block}, 2'b10);
    chk("buf_hold_res", fres(), 32'hCAFE_BABE);
    nedge(); ws_allowin = 1'b0; #1;
    chk("buf_hold2", fres(), 32'hCAFE_BABE);
    nedge(); ws_allowin = 1'b1; #1;
    chk("buf_exit", {ms_to_ws_valid, ms_allowin}, 2'b11);
    chk("buf_exit_res", fres(), 32'hCAFE_BABE);
    nedge(); #1;
    chk("buf_gone", ms_to_ws_valid, 0);

    // flush with waiting load and ES request outstanding: two stale responses
    enter(mk(1'b1, 5'b00001, 5'd4, 32'h0000_4000, 4'd0, 1'b0));
    nedge(); flush = 1'b1; es_req_outstanding = 1'b1; #1;
    chk("fl_kill", ms_to_ws_valid, 0);
    enter(mk(1'b1, 5'b00001, 5'd4, 32'h0000_5000, 4'd0, 1'b0));
    chk("fl_cnt", dut.cancel_cnt_q, 2);
    nedge(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111; #1;
    chk("fl_drop1", {ms_to_ws_valid, ms_load_block}, 2'b01);
    nedge(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222; #1;
    chk("fl_drop2", {ms_to_ws_valid, ms_load_block}, 2'b01);
    nedge(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333; #1;
    chk("fl_take", ms_to_ws_valid, 1);
    chk("fl_take_res", fres(), 32'h3333_3333);
    nedge(); #1;
    chk("fl_gone", ms_to_ws_valid, 0);

    // CSR + exception flags, and flush suppressing a ready ALU op
    enter(mk(1'b0, 5'd0, 5'd6, 32'h0000_00AA, 4'b0100, 1'b1));
    nedge(); #1;
    chk("csr_ex", {ms_csr_block, ms_ex}, 2'b11);
    flush = 1'b1; #1;
    chk("flush_same", ms_to_ws_valid, 0);
    nedge(); #1;
    chk("flush_clr", {ms_csr_block, ms_ex, ms_to_ds_bus[38]}, 3'b000);

    // async reset in the middle of a load
    enter(mk(1'b1, 5'b00001, 5'd8, 32'h0000_6000, 4'd0, 1'b0));
    nedge(); #1;
    chk("rst_pre", ms_load_block, 1);
    #1 reset = 1'b0; #1;
    chk("rst_async", {ms_load_block, ms_allowin, ms_to_ws_valid, ms_to_ds_bus[38]}, 4'b0100);
    nedge(); reset = 1'b1;
    nedge(); #1;
    chk("rst_after1", ms_to_ws_valid, 0);
    nedge(); #1;
    chk("rst_after2", {ms_to_ws_valid, ms_allowin}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, between the execute stage and the write-back stage. It holds one instruction and waits for the data-SRAM response of a load issued in execute. It aligns and extends load data and forms the 206-bit bus consumed by write-back. It also drops stale SRAM responses after a pipeline flush (exception or `ertn`) and publishes forwarding and blocking information to decode and execute.

## Interface
- No parameters. All widths are fixed by shared package constants.
- `clk` input 1: sole clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low; all state cleared while low.
- `es_to_ms_valid` input 1: execute stage offers an instruction.
- `es_to_ms_bus` input 212: {`res_from_mem`[211], `load_op`[210:206] = {ld_b, ld_bu, ld_h, ld_hu, ld_w}, payload[205:0]}. Payload layout is identical to `ms_to_ws_bus`; its `final_result` field holds the ALU result, which is the address for loads.
- `es_req_outstanding` input 1: execute holds a valid load whose SRAM request was accepted (addr_ok seen).
- `ms_allowin` output 1: stage can accept from execute.
- `ws_allowin` input 1: write-back can accept.
- `ms_to_ws_valid` output 1: instruction offered to write-back.
- `ms_to_ws_bus` output 206: {inst_rdcntid, data_sram_addr_error[31:0], ds_has_int, exception_op[3:0], rj_value, rkd_value, csr_data[33:0], gr_we, dest[4:0], final_result, pc}.
- `data_sram_data_ok` input 1: read/write response strobe.
- `data_sram_rdata` input 32: response data, valid with `data_ok`.
- `flush` input 1: `wb_ex | wb_ertn` from write-back.
- `ms_to_ds_bus` output 39: {`ms_valid`, `ms_gr_we`, `dest`[4:0], `fwd_data`[31:0]}, used for bypass.
- `ms_load_block` output 1: valid load whose data is not yet available.
- `ms_csr_block` output 1: valid csrrd/csrwr/csrxchg/rdcntid in this stage.
- `ms_ex` output 1: valid instruction carrying an exception, interrupt or ertn. Execute must suppress new memory requests while it is high.

## Operation
- `ms_valid` register. It is loaded with `es_to_ms_valid` when `ms_allowin`, and cleared by `flush`; flush has priority.
- The bus register captures `es_to_ms_bus` when `es_to_ms_valid && ms_allowin`.
- `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_ready_go = !res_from_mem || buf_valid || (data_ok && cancel_cnt==0)`.
- Response buffer (`buf_valid`, `buf_data`):
  - Set when an accepted `data_ok` arrives for a valid waiting load that cannot leave this cycle.
  - Cleared when the instruction leaves, or on flush.
- Cancel counter `cancel_cnt`, 2 bits, saturating at 3. On `flush`: `cancel_cnt <= cancel_cnt + (ms_valid && res_from_mem && !buf_valid && !accepted_now) + es_req_outstanding − drop_now`.
- `drop_now = data_ok && cancel_cnt!=0`. Each dropped `data_ok` decrements `cancel_cnt`; a dropped response never completes a load.
- Load extension uses addr[1:0] = `final_result[1:0]`:
  - ld_b/ld_bu: byte addr[1:0], sign- or zero-extended.
  - ld_h/ld_hu: half addr[1], sign- or zero-extended.
  - ld_w: whole word.
- Output `final_result` = extended load data when `res_from_mem`, otherwise the payload value. All other fields pass through unchanged.
- `ms_to_ws_valid = ms_valid && ms_ready_go && !flush`.
- `fwd_data` equals the output `final_result`. `ms_gr_we = gr_we && ms_valid`.

## Timing
- Reset values:
  - `ms_valid`, `buf_valid`, `cancel_cnt` = 0.
  - `ms_allowin` = 1.
  - `ms_to_ws_valid`, `ms_load_block`, `ms_csr_block`, `ms_ex` = 0.
  - Bus outputs are don't-care while not valid.
- Non-load: one cycle of residency; ready in its entry cycle.
- Load: exits in the same cycle `data_ok` arrives (combinational rdata path) when `ws_allowin`. If `ws_allowin` is low, it exits from the buffer on a later cycle.
- `data_ok` in the same cycle as `flush` is counted as accepted for a surviving load only if `cancel_cnt==0`. Because the load is being flushed, the response is discarded and no counter increment is made for it.
- `reset` asserted mid-load clears everything; the SRAM is assumed to be reset together with the core.

## Structure
- Shared package `pipe_pkg`:
  - Bus widths: ES→MS 212, MS→WS 206, MS→DS 39.
  - Payload field offsets.
  - `load_op` bit positions.
- Sub-module `mem_load_ext`: combinational aligner/extender (addr[1:0], load_op, rdata → 32-bit result).

## Test plan
- ALU op, result 0x1234_5678, `ws_allowin`=1 → `ms_to_ws_valid` 1 cycle after entry, `final_result` 0x1234_5678, `ms_to_ds_bus` = {1,1,dest,0x1234_5678}.
- ld_b addr 0x...3, rdata 0x80FF_0000, `data_ok` 2 cycles after entry → result 0xFFFF_FF80. `ms_load_block` is high for those 2 cycles and `ms_allowin` is 0.
- ld_hu addr 0x...2, rdata 0x8001_7FFF → 0x0000_8001. ld_h, same data and address → 0xFFFF_8001.
- Load, `data_ok` with `ws_allowin`=0 for 3 cycles → buffered; exits on the first cycle `ws_allowin`=1 with the correct data.
- `flush` while the MS load waits and `es_req_outstanding`=1 → `cancel_cnt`=2. The next two `data_ok` are dropped. A following load completes only on the third `data_ok`.
- Async `reset` low mid-load → all outputs return to reset values immediately; no WS transfer after release.
